// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padder that packs 32-bit big-endian beats into 512-bit blocks.
// Optional build macro SHA256_PADDER_CHK_EN adds a sticky `err` output for protocol/length faults.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
`ifdef SHA256_PADDER_CHK_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [1:0] {FILL = 2'd0, PAD = 2'd1, LEN = 2'd2, EMIT = 2'd3} state_t;

  // Final message word: keep the first n bytes, place the 0x80 marker at byte n, zero the rest.
  function automatic logic [31:0] last_word(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {d[31:24], 24'h80_0000};
      3'd2:    last_word = {d[31:16], 16'h8000};
      3'd3:    last_word = {d[31:8], 8'h80};
      default: last_word = d;
    endcase
  endfunction

  state_t           state_r;
  logic [4:0]       wcnt_r;
  logic [LEN_W-1:0] length_r;
  logic             first_flag_r;
  logic             pad_pend_r;
  logic             ovf_pend_r;
  logic             in_ready_r;
  logic             blk_valid_r;
  logic             blk_first_r;
  logic             blk_last_r;
  logic [511:0]     blk_data_r;

  logic             accept_s;
  logic [2:0]       n_eff_s;
  logic [5:0]       len_add_s;
  logic [LEN_W-1:0] len_next_s;
  logic [63:0]      len_field_s;
  logic [8:0]       wsel_s;

  assign accept_s    = in_valid && in_ready_r;
  assign n_eff_s     = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign len_add_s   = in_last ? {n_eff_s, 3'b000} : 6'd32;
  assign len_next_s  = length_r + LEN_W'(len_add_s);
  assign len_field_s = 64'(length_r);
  assign wsel_s      = {wcnt_r[3:0], 5'd0};

  // Block assembly; blk_data_r is also the word buffer, only meaningful while blk_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= FILL;
      wcnt_r       <= 5'd0;
      length_r     <= '0;
      first_flag_r <= 1'b1;
      pad_pend_r   <= 1'b0;
      ovf_pend_r   <= 1'b0;
      in_ready_r   <= 1'b0;
      blk_valid_r  <= 1'b0;
      blk_first_r  <= 1'b0;
      blk_last_r   <= 1'b0;
      blk_data_r   <= '0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            blk_data_r[wsel_s +: 32] <= in_last ? last_word(in_data, n_eff_s) : in_data;
            wcnt_r   <= wcnt_r + 5'd1;
            length_r <= len_next_s;
            if (in_last) begin
              pad_pend_r <= (n_eff_s == 3'd4);
              in_ready_r <= 1'b0;
              state_r    <= PAD;
            end else if (wcnt_r == 5'd15) begin
              in_ready_r  <= 1'b0;
              blk_valid_r <= 1'b1;
              blk_first_r <= first_flag_r;
              blk_last_r  <= 1'b0;
              ovf_pend_r  <= 1'b0;
              state_r     <= EMIT;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        PAD: begin
          // A full buffer is flushed first; a pending marker then lands in word 0 of the next block.
          if (wcnt_r == 5'd16) begin
            blk_valid_r <= 1'b1;
            blk_first_r <= first_flag_r;
            blk_last_r  <= 1'b0;
            ovf_pend_r  <= 1'b1;
            state_r     <= EMIT;
          end else if (pad_pend_r) begin
            blk_data_r[wsel_s +: 32] <= 32'h8000_0000;
            wcnt_r     <= wcnt_r + 5'd1;
            pad_pend_r <= 1'b0;
          end else if (wcnt_r == 5'd14) begin
            state_r <= LEN;
          end else begin
            blk_data_r[wsel_s +: 32] <= 32'h0000_0000;
            wcnt_r <= wcnt_r + 5'd1;
          end
        end
        LEN: begin
          blk_data_r[479:448] <= len_field_s[63:32];
          blk_data_r[511:480] <= len_field_s[31:0];
          wcnt_r      <= 5'd16;
          blk_valid_r <= 1'b1;
          blk_first_r <= first_flag_r;
          blk_last_r  <= 1'b1;
          state_r     <= EMIT;
        end
        EMIT: begin
          if (blk_ready) begin
            blk_valid_r <= 1'b0;
            blk_first_r <= 1'b0;
            blk_last_r  <= 1'b0;
            wcnt_r      <= 5'd0;
            if (blk_last_r) begin
              length_r     <= '0;
              first_flag_r <= 1'b1;
              in_ready_r   <= 1'b1;
              state_r      <= FILL;
            end else begin
              first_flag_r <= 1'b0;
              if (ovf_pend_r) begin
                ovf_pend_r <= 1'b0;
                state_r    <= PAD;
              end else begin
                in_ready_r <= 1'b1;
                state_r    <= FILL;
              end
            end
          end else begin
            blk_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign blk_valid = blk_valid_r;
  assign blk_first = blk_first_r;
  assign blk_last  = blk_last_r;
  assign blk_data  = blk_data_r;

`ifdef SHA256_PADDER_CHK_EN
  logic err_r;
  logic stall_r;

  // Sticky fault: oversize byte count on a last beat, length wrap, or valid withdrawn while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r   <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      stall_r <= in_valid && !in_ready_r;
      if ((accept_s && in_last && (in_nbytes > 3'd4)) ||
          (accept_s && (len_next_s < length_r)) ||
          (stall_r && !in_valid)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: byte-level padding reference model, vector table,
// randomized messages with backpressure, and hand-written reset/backpressure sequences.
module tb_sha256_padder;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;
`ifdef SHA256_PADDER_CHK_EN
  logic         err;
`endif

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
`ifdef SHA256_PADDER_CHK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [511:0] d; bit first; bit last; } blk_t;
  typedef struct { logic [31:0] d; bit last; logic [2:0] n; } beat_t;
  typedef struct { int len; bit use_n0; int exp_nblk; logic [31:0] exp_w15; } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  blk_t       exp_q[$];
  beat_t      beat_q[$];
  logic [7:0] msg[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit count, cut into 64-byte blocks.
  task automatic build_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    blk_t        b;
    int          nb;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      b.d = '0;
      for (int w = 0; w < 16; w++)
        b.d[32*w +: 32] = {p[64*k+4*w], p[64*k+4*w+1], p[64*k+4*w+2], p[64*k+4*w+3]};
      b.first = (k == 0);
      b.last  = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic build_beats(input bit use_n0, input bit rnd);
    beat_t bt;
    int    len;
    int    full;
    int    rem;
    len  = msg.size();
    full = len / 4;
    rem  = len % 4;
    beat_q.delete();
    for (int i = 0; i < full; i++) begin
      bt.d    = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      bt.last = 1'b0;
      bt.n    = 3'd4;
      if ((i == full - 1) && (rem == 0) && !use_n0) begin
        bt.last = 1'b1;
        if (rnd && ($urandom_range(0, 1) == 1)) bt.n = 3'($urandom_range(5, 7));
      end
      beat_q.push_back(bt);
    end
    if ((rem != 0) || use_n0 || (len == 0)) begin
      bt.d = $urandom();
      for (int j = 0; j < rem; j++) bt.d[31-8*j -: 8] = msg[4*full+j];
      bt.last = 1'b1;
      bt.n    = 3'(rem);
      beat_q.push_back(bt);
    end
  endtask

  // Streams the current msg through the DUT and scoreboards every block it emits.
  task automatic run_msg(input bit use_n0, input bit rnd, output int nblk, output logic [31:0] w15);
    blk_t         e;
    int           cyc;
    bit           pend;
    bit           hold;
    logic [511:0] hold_d;
    build_expected();
    build_beats(use_n0, rnd);
    nblk = 0;
    w15  = '0;
    pend = 1'b0;
    hold = 1'b0;
    hold_d = '0;
    cyc  = 0;
    while (((beat_q.size() > 0) || (exp_q.size() > 0)) && (cyc < 3000)) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", 512'(blk_valid), 512'd1);
        chk("hold_data", blk_data, hold_d);
      end
      blk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (blk_valid) chk("in_ready_in_emit", 512'(in_ready), 512'd0);
      hold   = blk_valid && !blk_ready;
      hold_d = blk_data;
      if (blk_valid && blk_ready) begin
        nblk++;
        w15 = blk_data[511:480];
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_block: got %0h expected none", blk_data);
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", blk_data, e.d);
          chk("blk_first", 512'(blk_first), 512'(e.first));
          chk("blk_last", 512'(blk_last), 512'(e.last));
        end
      end
      if (pend) begin
        beat_q.delete(0);
        in_valid = 1'b0;
        pend     = 1'b0;
      end
      if (!in_valid && (beat_q.size() > 0) && (!rnd || ($urandom_range(0, 3) != 0))) begin
        in_data   = beat_q[0].d;
        in_last   = beat_q[0].last;
        in_nbytes = beat_q[0].n;
        in_valid  = 1'b1;
      end
      if (in_valid && in_ready) pend = 1'b1;
    end
    if ((beat_q.size() > 0) || (exp_q.size() > 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d beats and %0d blocks outstanding, required 0", beat_q.size(), exp_q.size());
      beat_q.delete();
      exp_q.delete();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[11];
    int           nb;
    int           lat;
    int           len;
    bit           stable;
    logic [31:0]  w;
    logic [511:0] snap;
    logic [511:0] exp_blk;

    vt[0]  = '{0,   1'b0, 1, 32'h0000_0000};
    vt[1]  = '{3,   1'b0, 1, 32'h0000_0018};
    vt[2]  = '{4,   1'b1, 1, 32'h0000_0020};
    vt[3]  = '{4,   1'b0, 1, 32'h0000_0020};
    vt[4]  = '{55,  1'b0, 1, 32'h0000_01B8};
    vt[5]  = '{56,  1'b0, 2, 32'h0000_01C0};
    vt[6]  = '{56,  1'b1, 2, 32'h0000_01C0};
    vt[7]  = '{60,  1'b0, 2, 32'h0000_01E0};
    vt[8]  = '{64,  1'b0, 2, 32'h0000_0200};
    vt[9]  = '{64,  1'b1, 2, 32'h0000_0200};
    vt[10] = '{120, 1'b0, 3, 32'h0000_03C0};

    in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0; blk_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'd0);
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_first", 512'(blk_first), 512'd0);
    chk("rst_blk_last", 512'(blk_last), 512'd0);
    chk("rst_blk_data", blk_data, 512'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 512'(in_ready), 512'd1);

    // "abc" by hand: trailing garbage byte must be replaced by the marker; latency and backpressure.
    in_data = 32'h6162_635A; in_last = 1'b1; in_nbytes = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    lat = 0;
    while (!blk_valid && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat > 17) begin
      n_err++;
      $display("FAIL abc_latency: got %0d cycles, required at most 17", lat);
    end
    exp_blk = '0;
    exp_blk[31:0]    = 32'h6162_6380;
    exp_blk[511:480] = 32'h0000_0018;
    chk("abc_data", blk_data, exp_blk);
    chk("abc_first", 512'(blk_first), 512'd1);
    chk("abc_last", 512'(blk_last), 512'd1);
    snap = blk_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((blk_data !== snap) || !blk_valid || in_ready) stable = 1'b0;
    end
    chk("bp_stable", 512'(stable), 512'd1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk("bp_valid_drop", 512'(blk_valid), 512'd0);
    chk("bp_in_ready_back", 512'(in_ready), 512'd1);

    // Abort after 7 beats; reset must clear outputs immediately and restart cleanly.
    for (int i = 0; i < 7; i++) begin
      in_data = $urandom() | 32'h0000_0001; in_last = 1'b0; in_nbytes = 3'd4; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 512'(in_ready), 512'd0);
    chk("mid_rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("mid_rst_blk_data", blk_data, 512'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(1'b0, 1'b0, nb, w);
    chk("post_rst_nblk", 512'(nb), 512'd1);
    chk("post_rst_w15", 512'(w), 512'h18);

    for (int v = 0; v < 11; v++) begin
      msg.delete();
      for (int i = 0; i < vt[v].len; i++) msg.push_back(8'(32'h61 + i));
      run_msg(vt[v].use_n0, 1'b0, nb, w);
      chk("tbl_nblk", 512'(nb), 512'(vt[v].exp_nblk));
      chk("tbl_w15", 512'(w), 512'(vt[v].exp_w15));
    end

    for (int r = 0; r < 24; r++) begin
      len = $urandom_range(0, 200);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom()));
      run_msg(1'($urandom_range(0, 1)), 1'b1, nb, w);
      chk("rnd_nblk", 512'(nb), 512'((len + 8) / 64 + 1));
      chk("rnd_w15", 512'(w), 512'(32'(len * 8)));
    end

    @(negedge clk);
    blk_ready = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
